// File: rtl/imm_pkg.sv
// imm_pkg: immediate-format encodings and RV32I widths shared by decoder and immediate generator
package imm_pkg;
    localparam int IMM_IN_W = 25;
    localparam int XLEN     = 32;
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;
endpackage

// File: rtl/imm_extend_comb.sv
// imm_extend_comb: combinational RV32I immediate rearrangement; imm_i[k] holds instr[k+7]
module imm_extend_comb
    import imm_pkg::*;
(
    input  logic [IMM_IN_W-1:0] imm_i,
    input  logic [1:0]          immsrc_i,
    output logic [XLEN-1:0]     imm_ext_o
);
    always_comb begin
        imm_ext_o = {{20{imm_i[24]}}, imm_i[24:13]};
        case (imm_src_e'(immsrc_i))
            IMM_S:   imm_ext_o = {{20{imm_i[24]}}, imm_i[24:18], imm_i[4:0]};
            IMM_B:   imm_ext_o = {{20{imm_i[24]}}, imm_i[0], imm_i[23:18], imm_i[4:1], 1'b0};
            IMM_J:   imm_ext_o = {{12{imm_i[24]}}, imm_i[12:5], imm_i[13], imm_i[23:14], 1'b0};
            default: imm_ext_o = {{20{imm_i[24]}}, imm_i[24:13]};
        endcase
    end
endmodule

// File: rtl/imm_extend.sv
// imm_extend: registered RV32I immediate generator with synchronous active-low reset
module imm_extend
    import imm_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IMM_IN_W-1:0] imm_i,
    input  logic [1:0]          immsrc_i,
    output logic [XLEN-1:0]     imm_ext_o
);
    logic [XLEN-1:0] ext;
    imm_extend_comb u_comb (
        .imm_i     (imm_i),
        .immsrc_i  (immsrc_i),
        .imm_ext_o (ext)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_ni) imm_ext_o <= '0;
        else         imm_ext_o <= ext;
    end
endmodule

// File: tb/tb_imm_extend.sv
// tb_imm_extend: directed and random checks of imm_extend against an arithmetic reference model
module tb_imm_extend;
    import imm_pkg::*;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [24:0] imm_i = '0;
    logic [1:0]  immsrc_i = 2'b00;
    logic [31:0] imm_ext_o;
    int checks = 0;
    int errors = 0;

    imm_extend dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .imm_i     (imm_i),
        .immsrc_i  (immsrc_i),
        .imm_ext_o (imm_ext_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference built from the full instruction word with shifts and masks
    function automatic logic [31:0] ref_imm(logic [24:0] imm, logic [1:0] src);
        logic [31:0] ins;
        logic [31:0] sx;
        logic [31:0] sx_j;
        ins  = {imm, 7'b0};
        sx   = $signed(ins) >>> 20;
        sx_j = $signed(ins) >>> 11;
        case (src)
            2'b01:   return (sx & ~32'h1F) | ((ins >> 7) & 32'h1F);
            2'b10:   return (sx & ~32'h81F) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 8) & 32'hF) << 1);
            2'b11:   return (sx_j & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                            | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
            default: return sx;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] exp);
        checks++;
        assert (imm_ext_o === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, imm_ext_o, exp);
        end
    endtask

    task automatic apply(logic r, logic [24:0] i, logic [1:0] s);
        @(negedge clk_i);
        rst_ni   = r;
        imm_i    = i;
        immsrc_i = s;
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [24:0] PAT = 25'b0000000_11100_00000_000_11111;
    logic [31:0] exp_pat [4] = '{32'h0000_001C, 32'h0000_001F, 32'h0000_081E, 32'h0000_001C};
    logic [31:0] exp_sgn [4] = '{32'hFFFF_F800, 32'hFFFF_F800, 32'hFFFF_F000, 32'hFFF0_0000};
    logic [31:0] exp_one [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};

    initial begin
        apply(1'b0, 25'h1FFFFFF, 2'b11);
        check("reset_ones", 32'h0);
        apply(1'b0, 25'h0ABCDEF, 2'b10);
        check("reset_held", 32'h0);
        apply(1'b1, 25'h1FFFFFF, 2'b00);
        check("reset_release", 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, PAT, 2'(k));
            check($sformatf("pattern_%0d", k), exp_pat[k]);
        end
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 25'h1000000, 2'(k));
            check($sformatf("sign_%0d", k), exp_sgn[k]);
        end
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 25'h1FFFFFF, 2'(k));
            check($sformatf("ones_%0d", k), exp_one[k]);
        end
        apply(1'b1, PAT, 2'b00);
        check("latency_before", 32'h0000_001C);
        immsrc_i = 2'b10;
        @(negedge clk_i);
        check("latency_hold", 32'h0000_001C);
        @(posedge clk_i);
        #1;
        check("latency_update", 32'h0000_081E);
        apply(1'b0, PAT, 2'b01);
        check("reset_midstream", 32'h0);
        apply(1'b1, PAT, 2'b01);
        check("release_midstream", 32'h0000_001F);
        for (int n = 0; n < 1000; n++) begin
            logic [24:0] ri;
            logic [1:0]  rs;
            ri = 25'($urandom);
            rs = 2'($urandom_range(0, 3));
            apply(1'b1, ri, rs);
            check($sformatf("random_%0d_src%0d_imm%h", n, rs, ri), ref_imm(ri, rs));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
